// File: rtl/param_down_counter_if.sv
// param_down_counter_if: load/decrement control and status bundle for param_down_counter
interface param_down_counter_if #(
   parameter int WIDTH = 4
);
   logic             set;
   logic [WIDTH-1:0] load_val;
   logic             dec;
   logic             auto_reload;
   logic [WIDTH-1:0] count;
   logic             nill;
   logic             tc_pulse;
   logic             busy;
   logic             underflow;
   modport master (
      output set, load_val, dec, auto_reload,
      input  count, nill, tc_pulse, busy, underflow
   );
   modport slave (
      input  set, load_val, dec, auto_reload,
      output count, nill, tc_pulse, busy, underflow
   );
endinterface

// File: rtl/param_down_counter.sv
// param_down_counter: loadable down counter with auto-reload, tc pulse and sticky underflow; COUNTER_PRESCALE_EN adds a dec prescaler
module param_down_counter #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   param_down_counter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_count, r_reload;
   logic             r_tc, r_uf, w_run, w_acc, w_last;
   if (WIDTH < 2 || WIDTH > 16 || PRESCALE < 2 || PRESCALE > 256) begin : g_illegal_params
      $error("param_down_counter: WIDTH or PRESCALE out of range");
   end
   assign w_run  = r_state == RUN;
   assign w_last = r_count == WIDTH'(1);
`ifdef COUNTER_PRESCALE_EN
   localparam int PW = $clog2(PRESCALE);
   logic [PW-1:0] r_pre;
   assign w_acc = w_run && bus.dec && !bus.set && r_pre == PW'(PRESCALE - 1);
   // leaving RUN only happens via set or an accepted terminal decrement, both clear it
   always_ff @(posedge clk)
      if (!rst_n || bus.set || w_acc) r_pre <= '0;
      else if (w_run && bus.dec) r_pre <= r_pre + 1'b1;
`else
   assign w_acc = w_run && bus.dec && !bus.set;
`endif
   always_ff @(posedge clk)
      r_state <= !rst_n ? IDLE : w_next;
   always_comb
      w_next = bus.set ? (bus.load_val != '0 ? RUN : DONE)
             : (w_acc && w_last && !bus.auto_reload) ? DONE : r_state;
   always_ff @(posedge clk)
      if (!rst_n) begin
         r_count  <= '0;
         r_reload <= '0;
         r_tc     <= 1'b0;
         r_uf     <= 1'b0;
      end else begin
         r_tc <= w_acc && w_last;
         r_uf <= !bus.set && (r_uf || (bus.dec && !w_run));
         if (bus.set) begin
            r_count  <= bus.load_val;
            r_reload <= bus.load_val;
         end else if (w_acc) r_count <= w_last ? (bus.auto_reload ? r_reload : '0) : r_count - 1'b1;
      end
   always_comb begin
      bus.count     = r_count;
      bus.nill      = !w_run;
      bus.busy      = w_run;
      bus.tc_pulse  = r_tc;
      bus.underflow = r_uf;
   end
endmodule

// File: tb/tb_param_down_counter.sv
// tb_param_down_counter: directed plus random stimulus against an integer reference model, queue-based checking
module tb_param_down_counter;
   localparam int W = 4;
   localparam int P = 4;
`ifdef COUNTER_PRESCALE_EN
   localparam int STEP = P;
`else
   localparam int STEP = 1;
`endif
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;
   param_down_counter_if #(.WIDTH(W)) bus ();
   param_down_counter #(.WIDTH(W), .PRESCALE(P)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   typedef struct packed {
      logic [W-1:0] cnt;
      logic         nill;
      logic         busy;
      logic         tc;
      logic         uf;
   } exp_t;
   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   m_cnt, m_rel, m_pre;
   bit   m_run, m_uf, m_tc;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, act, req);
      end
   endtask
   // apply one cycle of inputs, advance the model and queue the expected outputs
   task automatic step(input bit r, input bit s, input int lv, input bit d, input bit a);
      rst_n           = r;
      bus.set         = s;
      bus.load_val    = W'(lv);
      bus.dec         = d;
      bus.auto_reload = a;
      m_tc = 0;
      if (!r) begin
         m_cnt = 0; m_rel = 0; m_pre = 0; m_run = 0; m_uf = 0;
      end else if (s) begin
         m_cnt = lv; m_rel = lv; m_pre = 0; m_uf = 0; m_run = lv != 0;
      end else if (d && !m_run) m_uf = 1;
      else if (d) begin
         m_pre++;
         if (m_pre == STEP) begin
            m_pre = 0;
            if (m_cnt > 1) m_cnt--;
            else begin
               m_tc = 1;
               if (a) m_cnt = m_rel;
               else begin
                  m_cnt = 0; m_run = 0;
               end
            end
         end
      end
      q.push_back('{W'(m_cnt), !m_run, m_run, m_tc, m_uf});
      @(negedge clk);
   endtask
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("count", 32'(bus.count), 32'(e.cnt));
            chk("nill", 32'(bus.nill), 32'(e.nill));
            chk("busy", 32'(bus.busy), 32'(e.busy));
            chk("tc_pulse", 32'(bus.tc_pulse), 32'(e.tc));
            chk("underflow", 32'(bus.underflow), 32'(e.uf));
         end
      end
   end
   initial begin
      step(0, 1, 15, 1, 1);
      step(0, 1, 15, 1, 1);
      step(1, 1, 7, 0, 0);
      repeat (7 * STEP) step(1, 0, 0, 1, 0);
      repeat (3) step(1, 0, 0, 1, 0);
      step(1, 1, 5, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 1, 3, 0, 1);
      repeat (9 * STEP) step(1, 0, 0, 1, 1);
      step(1, 1, 4, 0, 0);
      step(1, 1, 9, 1, 0);
      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 1, 0);
      step(1, 0, 0, 0, 0);
      step(1, 1, 2, 0, 0);
      repeat (8) step(1, 0, 0, 1, 0);
      step(1, 1, 1, 0, 1);
      repeat (4 * STEP) step(1, 0, 0, 1, 1);
      repeat (STEP) step(1, 0, 0, 1, 0);
      step(1, 1, 15, 0, 0);
      repeat (16 * STEP) step(1, 0, 0, 1, 0);
      repeat (3000) begin
         int lv;
         lv = ($urandom_range(3) == 0) ? int'($urandom_range(2)) : int'($urandom_range(2 ** W - 1));
         step($urandom_range(63) != 0, $urandom_range(7) == 0, lv, $urandom_range(3) != 0, 1'($urandom_range(1)));
      end
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
